// File: rtl/uart_link_agent.sv
// Serial-link agent: buffered UART transmitter driving rx_out plus a UART receive monitor on tx_in.
// Define UART_PARITY_EN to add one even-parity bit to both engines and the mon_parity_err output.
module uart_link_agent #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_valid,
    input  logic [7:0]                  push_data,
    output logic                        push_ready,
    output logic                        rx_out,
    input  logic                        tx_in,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        mon_valid,
    output logic [7:0]                  mon_data,
    output logic                        mon_frame_err
`ifdef UART_PARITY_EN
    ,
    output logic                        mon_parity_err
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLK_DIV / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

`ifdef UART_PARITY_EN
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        fifo_count_q, fifo_count_d;
    logic                 push_ready_q, push_ready_d;
    logic                 push_fire_s, pop_s, fifo_empty_s;
    logic [DATA_BITS-1:0] head_s;

    state_e               tx_state_q, tx_state_d;
    logic [BW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 rx_out_q, rx_out_d, tx_busy_q, tx_busy_d;

    logic                 rx_sync1_q, rx_sync2_q, rx_prev_q;
    state_e               rx_state_q, rx_state_d;
    logic [BW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 mon_valid_q, mon_valid_d, mon_frame_err_q, mon_frame_err_d;
    logic [7:0]           mon_data_q, mon_data_d;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d, rx_par_q, rx_par_d;
    logic                 mon_parity_err_q, mon_parity_err_d;
    assign mon_parity_err = mon_parity_err_q;
`endif

    assign push_ready    = push_ready_q;
    assign fifo_count    = fifo_count_q;
    assign rx_out        = rx_out_q;
    assign tx_busy       = tx_busy_q;
    assign mon_valid     = mon_valid_q;
    assign mon_data      = mon_data_q;
    assign mon_frame_err = mon_frame_err_q;

    assign head_s       = fifo_mem_q[rd_ptr_q];
    assign fifo_empty_s = (fifo_count_q == {CW{1'b0}});
    // push_ready is the registered not-full flag, so a full FIFO refuses even during a pop
    assign push_fire_s  = push_valid && push_ready_q;

    // FIFO pointer, occupancy and storage update
    always_comb begin
        fifo_mem_d           = fifo_mem_q;
        fifo_mem_d[wr_ptr_q] = push_fire_s ? push_data[DATA_BITS-1:0] : fifo_mem_q[wr_ptr_q];
        wr_ptr_d             = push_fire_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d             = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_fire_s, pop_s})
            2'b10:   fifo_count_d = fifo_count_q + CNT_ONE;
            2'b01:   fifo_count_d = fifo_count_q - CNT_ONE;
            default: fifo_count_d = fifo_count_q;
        endcase
        push_ready_d = (fifo_count_d != CNT_FULL);
    end

    // Transmit FSM; rx_out is registered from the current state, so the line trails the state by one cycle
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        pop_s      = 1'b0;
        rx_out_d   = 1'b1;
        case (tx_state_q)
            ST_IDLE: begin
                rx_out_d = 1'b1;
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    tx_shift_d = head_s;
                    tx_cnt_d   = {BW{1'b0}};
                    tx_state_d = ST_START;
                end else begin
                    tx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                rx_out_d = 1'b0;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = {BW{1'b0}};
                    tx_idx_d   = 4'd0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + BIT_ONE;
                end
            end
            ST_DATA: begin
                rx_out_d = tx_shift_q[0];
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = {BW{1'b0}};
                    tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                    if (tx_idx_q == DATA_LAST) begin
                        tx_idx_d = 4'd0;
`ifdef UART_PARITY_EN
                        tx_state_d = ST_PARITY;
`else
                        tx_state_d = ST_STOP;
`endif
                    end else begin
                        tx_idx_d = tx_idx_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + BIT_ONE;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                rx_out_d = tx_par_q;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = {BW{1'b0}};
                    tx_state_d = ST_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + BIT_ONE;
                end
            end
`endif
            ST_STOP: begin
                rx_out_d = 1'b1;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = {BW{1'b0}};
                    if (tx_idx_q == STOP_LAST) begin
                        tx_idx_d = 4'd0;
                        if (!fifo_empty_s) begin
                            pop_s      = 1'b1;
                            tx_shift_d = head_s;
                            tx_state_d = ST_START;
                        end else begin
                            tx_state_d = ST_IDLE;
                        end
                    end else begin
                        tx_idx_d = tx_idx_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + BIT_ONE;
                end
            end
            default: begin
                rx_out_d   = 1'b1;
                tx_state_d = ST_IDLE;
            end
        endcase
        tx_busy_d = (tx_state_q != ST_IDLE) || !fifo_empty_s;
    end

`ifdef UART_PARITY_EN
    assign tx_par_d = pop_s ? even_parity(head_s) : tx_par_q;
`endif

    // Receive monitor FSM, sampling the synchronised line at mid-bit
    always_comb begin
        rx_state_d      = rx_state_q;
        rx_cnt_d        = rx_cnt_q;
        rx_idx_d        = rx_idx_q;
        rx_shift_d      = rx_shift_q;
        mon_valid_d     = 1'b0;
        mon_data_d      = mon_data_q;
        mon_frame_err_d = mon_frame_err_q;
`ifdef UART_PARITY_EN
        rx_par_d         = rx_par_q;
        mon_parity_err_d = mon_parity_err_q;
`endif
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = {BW{1'b0}};
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_state_d = ST_START;
                end else begin
                    rx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = {BW{1'b0}};
                    rx_idx_d   = 4'd0;
                    rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + BIT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = {BW{1'b0}};
                    rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == DATA_LAST) begin
                        rx_idx_d = 4'd0;
`ifdef UART_PARITY_EN
                        rx_state_d = ST_PARITY;
`else
                        rx_state_d = ST_STOP;
`endif
                    end else begin
                        rx_idx_d = rx_idx_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + BIT_ONE;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = {BW{1'b0}};
                    rx_par_d   = rx_sync2_q;
                    rx_state_d = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + BIT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d        = {BW{1'b0}};
                    mon_valid_d     = 1'b1;
                    mon_data_d      = 8'(rx_shift_q);
                    mon_frame_err_d = !rx_sync2_q;
`ifdef UART_PARITY_EN
                    mon_parity_err_d = rx_par_q ^ even_parity(rx_shift_q);
`endif
                    rx_state_d = ST_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + BIT_ONE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // FIFO storage is a pure data path and carries no reset
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    // Transmit-side state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            fifo_count_q <= {CW{1'b0}};
            push_ready_q <= 1'b1;
            tx_state_q   <= ST_IDLE;
            tx_cnt_q     <= {BW{1'b0}};
            tx_idx_q     <= 4'd0;
            tx_shift_q   <= {DATA_BITS{1'b0}};
            rx_out_q     <= 1'b1;
            tx_busy_q    <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            push_ready_q <= push_ready_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_idx_q     <= tx_idx_d;
            tx_shift_q   <= tx_shift_d;
            rx_out_q     <= rx_out_d;
            tx_busy_q    <= tx_busy_d;
`ifdef UART_PARITY_EN
            tx_par_q     <= tx_par_d;
`endif
        end
    end

    // Monitor registers; synchroniser resets high so no false edge follows reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1_q      <= 1'b1;
            rx_sync2_q      <= 1'b1;
            rx_prev_q       <= 1'b1;
            rx_state_q      <= ST_IDLE;
            rx_cnt_q        <= {BW{1'b0}};
            rx_idx_q        <= 4'd0;
            rx_shift_q      <= {DATA_BITS{1'b0}};
            mon_valid_q     <= 1'b0;
            mon_data_q      <= 8'h00;
            mon_frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q         <= 1'b0;
            mon_parity_err_q <= 1'b0;
`endif
        end else begin
            rx_sync1_q      <= tx_in;
            rx_sync2_q      <= rx_sync1_q;
            rx_prev_q       <= rx_sync2_q;
            rx_state_q      <= rx_state_d;
            rx_cnt_q        <= rx_cnt_d;
            rx_idx_q        <= rx_idx_d;
            rx_shift_q      <= rx_shift_d;
            mon_valid_q     <= mon_valid_d;
            mon_data_q      <= mon_data_d;
            mon_frame_err_q <= mon_frame_err_d;
`ifdef UART_PARITY_EN
            rx_par_q         <= rx_par_d;
            mon_parity_err_q <= mon_parity_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_link_agent.sv
// Self-checking bench for uart_link_agent: scoreboard of expected monitor bytes plus recorded rx_out waveforms.
module tb_uart_link_agent;
    localparam int CLK_DIV    = 4;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
    localparam int FRAME_CYC  = FRAME_BITS * CLK_DIV;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push_valid = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       push_ready, rx_out, tx_busy, mon_valid, mon_frame_err;
    logic [2:0] fifo_count;
    logic [7:0] mon_data;
    logic       tx_in;
    logic       tx_drv = 1'b1;
    logic       loop_en = 1'b0;
`ifdef UART_PARITY_EN
    logic       mon_parity_err;
`endif

    int   checks = 0;
    int   errors = 0;
    int   mon_count = 0;
    exp_t sb[$];
    logic rec_rx[$];
    logic rec_busy[$];
    logic rec_en = 1'b0;
    exp_t mon_e;

    assign tx_in = loop_en ? rx_out : tx_drv;

    uart_link_agent #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .rx_out(rx_out), .tx_in(tx_in), .tx_busy(tx_busy),
        .fifo_count(fifo_count), .mon_valid(mon_valid), .mon_data(mon_data),
        .mon_frame_err(mon_frame_err)
`ifdef UART_PARITY_EN
        , .mon_parity_err(mon_parity_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t mk_exp(input logic [7:0] d, input logic f, input logic p);
        exp_t e;
        e.data = d;
        e.ferr = f;
        e.perr = p;
        return e;
    endfunction

    // Expected line level for bit k of a frame carrying d
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        else if (k <= DATA_BITS) return d[k-1];
        else if (PAR_BITS == 1 && k == DATA_BITS + 1) return ^d;
        else return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (rec_en) begin
            rec_rx.push_back(rx_out);
            rec_busy.push_back(tx_busy);
        end
    end

    always @(negedge clk) begin
        if (mon_valid === 1'b1) begin
            mon_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected: got data=%h ferr=%b with nothing expected", mon_data, mon_frame_err);
            end else begin
                mon_e = sb.pop_front();
                if (mon_data !== mon_e.data || mon_frame_err !== mon_e.ferr
`ifdef UART_PARITY_EN
                    || mon_parity_err !== mon_e.perr
`endif
                ) begin
                    errors++;
                    $display("FAIL mon_byte: got data=%h ferr=%b want data=%h ferr=%b perr=%b",
                             mon_data, mon_frame_err, mon_e.data, mon_e.ferr, mon_e.perr);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_val, input logic par_flip);
        logic b;
        for (int k = 0; k < FRAME_BITS; k++) begin
            b = exp_bit(d, k);
            if (k == FRAME_BITS - 1) b = stop_val;
            if (PAR_BITS == 1 && k == DATA_BITS + 1) b = b ^ par_flip;
            tx_drv = b;
            repeat (CLK_DIV) cyc();
        end
        tx_drv = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && sb.size() != 0; i++) cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected bytes never decoded, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) cyc();
        checks++; if (rx_out !== 1'b1) begin errors++; $display("FAIL rst_rx_out: got %b want 1", rx_out); end
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL rst_push_ready: got %b want 1", push_ready); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_fifo_count: got %0d want 0", fifo_count); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_tx_busy: got %b want 0", tx_busy); end
        checks++; if (mon_valid !== 1'b0) begin errors++; $display("FAIL rst_mon_valid: got %b want 0", mon_valid); end
        checks++; if (mon_data !== 8'h00 || mon_frame_err !== 1'b0) begin
            errors++; $display("FAIL rst_mon_data: got %h/%b want 00/0", mon_data, mon_frame_err); end
        reset = 1'b0;
        bad = 0;
        repeat (100) begin
            cyc();
            if (rx_out !== 1'b1 || push_ready !== 1'b1 || fifo_count !== 3'd0 || mon_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_100: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_loopback_a5();
        int bad;
        int m0;
        loop_en = 1'b1;
        m0 = mon_count;
        rec_rx.delete(); rec_busy.delete();
        push_data = 8'hA5; push_valid = 1'b1; rec_en = 1'b1;
        sb.push_back(mk_exp(8'hA5, 1'b0, 1'b0));
        cyc();
        push_valid = 1'b0;
        repeat (FRAME_CYC + 8) cyc();
        rec_en = 1'b0;
        checks++; if (rec_rx[2] !== 1'b1) begin errors++; $display("FAIL a5_pre_start: got %b want 1", rec_rx[2]); end
        for (int b = 0; b < FRAME_BITS; b++) begin
            bad = 0;
            for (int c = 0; c < CLK_DIV; c++)
                if (rec_rx[3 + b*CLK_DIV + c] !== exp_bit(8'hA5, b)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL a5_bit%0d: got %b in %0d cycles want %b", b, rec_rx[3 + b*CLK_DIV], bad, exp_bit(8'hA5, b));
            end
        end
        checks++; if (rec_rx[3 + FRAME_CYC] !== 1'b1) begin errors++; $display("FAIL a5_post_idle: got %b want 1", rec_rx[3 + FRAME_CYC]); end
        checks++; if (rec_busy[2 + FRAME_CYC] !== 1'b1 || rec_busy[3 + FRAME_CYC] !== 1'b0) begin
            errors++; $display("FAIL a5_busy_fall: got %b%b want 10", rec_busy[2 + FRAME_CYC], rec_busy[3 + FRAME_CYC]); end
        wait_drain("a5");
        repeat (10) cyc();
        checks++; if (mon_count != m0 + 1) begin errors++; $display("FAIL a5_mon_pulses: got %0d want 1", mon_count - m0); end
    endtask

    task automatic test_fifo_burst();
        logic [7:0] bytes [6];
        logic       exp_rdy;
        int         bad;
        int         base;
        bytes = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hF0, 8'h0F};
        loop_en = 1'b1;
        rec_rx.delete(); rec_busy.delete();
        rec_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_data = bytes[i]; push_valid = 1'b1;
            exp_rdy = (i < 5) ? 1'b1 : 1'b0;
            checks++;
            if (push_ready !== exp_rdy) begin errors++; $display("FAIL burst_ready%0d: got %b want %b", i, push_ready, exp_rdy); end
            if (i < 5) sb.push_back(mk_exp(bytes[i], 1'b0, 1'b0));
            cyc();
        end
        push_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL burst_count: got %0d want 4", fifo_count); end
        repeat (5*FRAME_CYC + 6) cyc();
        rec_en = 1'b0;
        bad = 0;
        for (int f = 0; f < 5; f++)
            for (int b = 0; b < FRAME_BITS; b++)
                for (int c = 0; c < CLK_DIV; c++)
                    if (rec_rx[3 + f*FRAME_CYC + b*CLK_DIV + c] !== exp_bit(bytes[f], b)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL burst_waveform: got %0d wrong cycles want 0", bad); end
        base = 3 + 5*FRAME_CYC;
        checks++; if (rec_rx[base] !== 1'b1 || rec_busy[base] !== 1'b0 || rec_busy[base-1] !== 1'b1) begin
            errors++; $display("FAIL burst_end: got rx=%b busy=%b%b want rx=1 busy=10", rec_rx[base], rec_busy[base-1], rec_busy[base]); end
        wait_drain("burst");
    endtask

    task automatic test_glitch_frame_err();
        int m0;
        loop_en = 1'b0; tx_drv = 1'b1;
        repeat (4) cyc();
        m0 = mon_count;
        tx_drv = 1'b0;
        cyc();
        tx_drv = 1'b1;
        repeat (30) cyc();
        checks++; if (mon_count != m0) begin errors++; $display("FAIL glitch: got %0d pulses want 0", mon_count - m0); end
        sb.push_back(mk_exp(8'h3C, 1'b1, 1'b0));
        drive_frame(8'h3C, 1'b0, 1'b0);
        repeat (4) cyc();
        wait_drain("ferr");
        checks++; if (mon_count != m0 + 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", mon_count - m0); end
    endtask

    task automatic test_reset_mid();
        int m0;
        int bad;
        loop_en = 1'b1;
        push_data = 8'hFF; push_valid = 1'b1;
        cyc();
        push_data = 8'h0F;
        cyc();
        push_valid = 1'b0;
        repeat (18) cyc();
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL mid_count_pre: got %0d want 1", fifo_count); end
        m0 = mon_count;
        reset = 1'b1;
        cyc();
        checks++; if (rx_out !== 1'b1) begin errors++; $display("FAIL mid_rx_out: got %b want 1", rx_out); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", tx_busy); end
        checks++; if (mon_valid !== 1'b0) begin errors++; $display("FAIL mid_mon_valid: got %b want 0", mon_valid); end
        reset = 1'b0;
        bad = 0;
        repeat (100) begin
            cyc();
            if (rx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_idle: got %0d bad cycles want 0", bad); end
        checks++; if (mon_count != m0) begin errors++; $display("FAIL mid_no_mon: got %0d pulses want 0", mon_count - m0); end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int bad;
        loop_en = 1'b1;
        rec_rx.delete(); rec_busy.delete();
        push_data = 8'h07; push_valid = 1'b1; rec_en = 1'b1;
        sb.push_back(mk_exp(8'h07, 1'b0, 1'b0));
        cyc();
        push_valid = 1'b0;
        repeat (FRAME_CYC + 8) cyc();
        rec_en = 1'b0;
        bad = 0;
        for (int c = 0; c < CLK_DIV; c++)
            if (rec_rx[3 + (DATA_BITS+1)*CLK_DIV + c] !== 1'b1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL par_tx_bit: got %0d low cycles want 0", bad); end
        wait_drain("par_ok");
        loop_en = 1'b0; tx_drv = 1'b1;
        repeat (4) cyc();
        sb.push_back(mk_exp(8'h07, 1'b0, 1'b1));
        drive_frame(8'h07, 1'b1, 1'b1);
        wait_drain("par_err");
    endtask
`endif

    initial begin
        test_reset();
        test_loopback_a5();
        test_fifo_burst();
        test_glitch_frame_err();
        test_reset_mid();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        repeat (10) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_link_agent.md
# uart_link_agent

Parametrised serial-link agent for the MIPS core simulation and bring-up environment. It replaces the static `rx` tie-off with two engines:
- a buffered UART transmitter that drives the core's `rx` input;
- a UART receive monitor that decodes bytes from the core's `tx` output.

Baud divisor, data width, stop bits and buffer depth are configurable. The block sits beside `Core` in benches and FPGA harnesses.

## Interface
- `CLK_DIV`, 16: clk cycles per bit; legal range ≥ 4.
- `DATA_BITS`, 8: data bits per frame; legal range 5..8.
- `STOP_BITS`, 1: stop bits driven on transmit; legal values 1 or 2.
- `FIFO_DEPTH`, 8: transmit byte buffer entries; must be a power of two, ≥ 2.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `push_valid`  in  1  byte offered for transmit.
- `push_data`  in  8  byte to transmit; bits above `DATA_BITS` are ignored.
- `push_ready`  out  1  FIFO can accept a byte. Reset value 1.
- `rx_out`  out  1  serial line to the core's `rx`. Idles high. Reset value 1.
- `tx_in`  in  1  serial line from the core's `tx`. Asynchronous.
- `tx_busy`  out  1  frame in flight or FIFO non-empty. Reset value 0.
- `fifo_count`  out  log2(FIFO_DEPTH)+1  occupied entries. Reset value 0.
- `mon_valid`  out  1  one-cycle pulse: a decoded byte is available. Reset value 0.
- `mon_data`  out  8  decoded byte, zero-extended above `DATA_BITS`. Reset value 0.
- `mon_frame_err`  out  1  qualifies `mon_valid`: the stop bit was sampled low. Reset value 0.

## Operation
- **Transfer:** a byte is transferred when `push_valid && push_ready` at a rising edge.
- **FIFO:** `push_ready = (fifo_count != FIFO_DEPTH)`.
  - When full, `push_ready` stays low even if a pop occurs in the same cycle.
  - A push while not ready is dropped.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
- **Transmit FSM:** states IDLE → START → DATA → STOP → IDLE.
  - IDLE with FIFO non-empty: pop the head into the shift register, go to START.
  - START drives 0. DATA drives data bits LSB first. STOP drives 1 for `STOP_BITS` bit times.
  - Each bit is held exactly `CLK_DIV` cycles, timed by a bit counter that reloads per bit.
  - From STOP, if the FIFO is non-empty, pop and go straight to START. There is no idle gap beyond the stop bits.
- **Receive monitor:** `tx_in` passes through a 2-flop synchronizer, then states IDLE → START → DATA → STOP.
  - IDLE: a synchronized falling edge starts a count of `CLK_DIV/2` to mid start bit.
  - START: if the line is high at mid start bit, it is a glitch; return to IDLE with no output. If low, sample every `CLK_DIV` cycles thereafter.
  - DATA: shift in `DATA_BITS` bits LSB first.
  - STOP: only the first stop bit is checked. Low sets `mon_frame_err` alongside the pulse.
  - After STOP the monitor returns to IDLE and re-arms immediately, so back-to-back frames are decoded.
- **Independence:** transmit and monitor are fully independent. Loopback of `rx_out` to `tx_in` is legal.
- **Reset mid-operation:**
  - FIFO is emptied and both FSMs return to IDLE.
  - `rx_out` is 1 from the cycle after reset is sampled. A partially sent frame is truncated, not completed.
  - Any partially received byte is discarded and `mon_valid` is 0.

## Timing
- **Push to start bit:** push at edge N into an empty FIFO with the transmit FSM idle. The pop occurs at edge N+1 and `rx_out` falls after edge N+2.
- **Frame length:** (1 + DATA_BITS + [PARITY_EN] + STOP_BITS) × CLK_DIV cycles.
- **`tx_busy`:** falls the cycle after the last stop bit completes, provided the FIFO is empty.
- **Monitor latency:** from the `tx_in` falling edge to `mon_valid` is 2 (sync) + CLK_DIV/2 + (DATA_BITS + [PARITY_EN] + 1) × CLK_DIV cycles, ±1.
- **Outputs:** `mon_data` and `mon_frame_err` hold their values until the next `mon_valid`. All outputs are registered.

## Configuration
- **`UART_PARITY_EN` defined:** one even-parity bit is inserted after the data bits.
  - Transmit: PARITY state between DATA and STOP, driving the XOR of the data bits.
  - Monitor: checks the received parity bit and adds output `mon_parity_err` (1 bit, qualifies `mon_valid`, reset value 0).
- **Undefined:** no parity bit, no PARITY state, and the `mon_parity_err` port is absent.

## Test plan
- Reset, then idle 100 cycles → `rx_out`=1, `push_ready`=1, `fifo_count`=0, `mon_valid` never asserted.
- CLK_DIV=4, push 0xA5 with `rx_out` looped to `tx_in` → `rx_out` pattern 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `mon_valid` pulses once with `mon_data`=0xA5 and `mon_frame_err`=0.
- FIFO_DEPTH=4, push 6 bytes on consecutive cycles while transmit is idle:
  - push 1 is accepted and popped by the transmitter;
  - pushes 2–5 fill the FIFO to 4, and `push_ready` falls;
  - push 6 is dropped;
  - five frames are sent back to back with no gap beyond the stop bits.
- Drive `tx_in` low for 1 cycle only → no `mon_valid` (glitch rejected). Drive a full frame 0x3C with the stop bit held low → `mon_valid`=1, `mon_data`=0x3C, `mon_frame_err`=1.
- Assert `reset` during the 4th data bit of 0xFF → `rx_out`=1 next cycle, `fifo_count`=0, `tx_busy`=0, no `mon_valid` for the truncated frame.
- With `UART_PARITY_EN`, send 0x07 → parity bit driven 1. Inject a flipped parity bit into `tx_in` → `mon_parity_err`=1 with `mon_data`=0x07.
